// File: rtl/muldiv_if.sv
// Request/response handshake bundle between the execute stage and the MULDIV sequencer.
interface muldiv_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_funct3;
    logic [XLEN-1:0]  req_rs1;
    logic [XLEN-1:0]  req_rs2;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [XLEN-1:0]  rsp_data;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output req_valid, req_funct3, req_rs1, req_rs2, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag
    );

    modport slave (
        input  req_valid, req_funct3, req_rs1, req_rs2, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag
    );
endinterface

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer: shared 32-step shift-add / restoring-divide datapath.
// Optional build macro MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle one.
module muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    muldiv_if.slave  bus,
    output logic     busy
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    logic [1:0]       state;
    logic [5:0]       cnt;
    logic [5:0]       cnt_n;
    logic [XLEN-1:0]  rsp_data;
    logic [TAG_W-1:0] rsp_tag;

    logic [XLEN:0]    hi;
    logic [XLEN-1:0]  lo;
    logic [XLEN-1:0]  opnd;
    logic [2:0]       op;
    logic             neg_q;
    logic             neg_r;

    logic [2:0]       f3;
    logic             is_mul;
    logic             a_signed;
    logic             b_signed;
    logic             sa;
    logic             sb;
    logic [XLEN-1:0]  a_mag;
    logic [XLEN-1:0]  b_mag;
    logic             div_zero;
    logic             div_ovf;
    logic [XLEN-1:0]  special_res;

    always_comb begin
        f3          = bus.req_funct3;
        is_mul      = ~f3[2];
        a_signed    = is_mul ? (f3[1:0] == 2'b01 || f3[1:0] == 2'b10) : ~f3[0];
        b_signed    = is_mul ? (f3[1:0] == 2'b01) : ~f3[0];
        sa          = a_signed & bus.req_rs1[XLEN-1];
        sb          = b_signed & bus.req_rs2[XLEN-1];
        a_mag       = cond_neg(bus.req_rs1, sa);
        b_mag       = cond_neg(bus.req_rs2, sb);
        div_zero    = (bus.req_rs2 == '0);
        div_ovf     = ~f3[0] && (bus.req_rs1 == {1'b1, {(XLEN-1){1'b0}}})
                             && (bus.req_rs2 == {XLEN{1'b1}});
        // Overflow quotient equals the dividend itself; zero-divisor remainder is the dividend too
        if (div_zero)
            special_res = f3[1] ? bus.req_rs1 : {XLEN{1'b1}};
        else
            special_res = f3[1] ? '0 : bus.req_rs1;
    end

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     mul_hi_n;
    logic [XLEN-1:0]   mul_lo_n;
    logic [2*XLEN-1:0] mul_prod;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN:0]     div_shift;
    logic [XLEN+1:0]   div_diff;
    logic              div_ge;
    logic [XLEN:0]     div_hi_n;
    logic [XLEN-1:0]   div_lo_n;
    logic [XLEN-1:0]   div_res;

    always_comb begin
        // hi stays below 2^XLEN between steps, so the 33-bit sum never overflows
        mul_sum   = lo[0] ? (hi + {1'b0, opnd}) : hi;
        mul_hi_n  = {1'b0, mul_sum[XLEN:1]};
        mul_lo_n  = {mul_sum[0], lo[XLEN-1:1]};
        mul_prod  = cond_neg_wide({mul_hi_n[XLEN-1:0], mul_lo_n}, neg_q);
        mul_res   = (op == 3'b000) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

        div_shift = {hi[XLEN-1:0], lo[XLEN-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opnd};
        div_ge    = ~div_diff[XLEN+1];
        div_hi_n  = div_ge ? div_diff[XLEN:0] : div_shift;
        div_lo_n  = {lo[XLEN-2:0], div_ge};
        div_res   = op[1] ? cond_neg(div_hi_n[XLEN-1:0], neg_r) : cond_neg(div_lo_n, neg_q);

        cnt_n     = cnt + 6'd1;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fast_a;
    logic signed [XLEN:0]     fast_b;
    logic signed [2*XLEN+1:0] fast_p;
    logic [XLEN-1:0]          fast_res;

    always_comb begin
        fast_a   = {a_signed & bus.req_rs1[XLEN-1], bus.req_rs1};
        fast_b   = {b_signed & bus.req_rs2[XLEN-1], bus.req_rs2};
        fast_p   = fast_a * fast_b;
        fast_res = (f3 == 3'b000) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            rsp_data <= '0;
            rsp_tag  <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (bus.req_valid) begin
                    rsp_tag <= bus.req_tag;
                    cnt     <= '0;
                    if (is_mul) begin
`ifdef MULDIV_FAST_MUL_EN
                        state    <= ST_DONE;
                        rsp_data <= fast_res;
`else
                        state    <= ST_MUL;
`endif
                    end else if (div_zero || div_ovf) begin
                        state    <= ST_DONE;
                        rsp_data <= special_res;
                    end else begin
                        state    <= ST_DIV;
                    end
                end
                ST_MUL: begin
                    cnt <= cnt_n;
                    if (cnt_n == 6'd32) begin
                        state    <= ST_DONE;
                        rsp_data <= mul_res;
                    end
                end
                ST_DIV: begin
                    cnt <= cnt_n;
                    if (cnt_n == 6'd32) begin
                        state    <= ST_DONE;
                        rsp_data <= div_res;
                    end
                end
                default: if (bus.rsp_ready) state <= ST_IDLE;
            endcase
        end
    end

    // Datapath registers carry no reset; they are always loaded on acceptance
    always_ff @(posedge clk) begin
        case (state)
            ST_IDLE: if (bus.req_valid) begin
                op    <= f3;
                hi    <= '0;
                lo    <= is_mul ? b_mag : a_mag;
                opnd  <= is_mul ? a_mag : b_mag;
                neg_q <= sa ^ sb;
                neg_r <= sa;
            end
            ST_MUL: begin
                hi <= mul_hi_n;
                lo <= mul_lo_n;
            end
            ST_DIV: begin
                hi <= div_hi_n;
                lo <= div_lo_n;
            end
            default: ;
        endcase
    end

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.rsp_valid = (state == ST_DONE);
    assign bus.rsp_data  = rsp_data;
    assign bus.rsp_tag   = rsp_tag;
    assign busy          = (state != ST_IDLE);
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed operations, specials, backpressure, flush and reset abort.
module tb_muldiv_seq;
`ifdef MULDIV_FAST_MUL_EN
    localparam int LM = 1;
`else
    localparam int LM = 33;
`endif
    localparam int LD = 33;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic busy;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    muldiv_if m ();

    muldiv_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (m),
        .busy  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        int          cyc;
    } exp_t;
    exp_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] exp, input int lat,
                         input bit push, output int acc);
        int n = 0;
        m.req_valid = 1'b1; m.req_funct3 = f3; m.req_rs1 = a; m.req_rs2 = b; m.req_tag = tag;
        while (!m.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests++; fails++;
            $display("FAIL issue_timeout: req_ready stayed %b, expected 1", m.req_ready);
            acc = -1;
        end else begin
            acc = cyc;
            if (push) q.push_back('{exp, tag, cyc + lat});
            @(negedge clk);
        end
        m.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            tests++; fails++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", q.size());
        end
    endtask

    // Monitor: checks response cycle, hold stability and pops on handshake
    initial begin
        logic        held = 1'b0;
        logic [31:0] cd = '0;
        logic [4:0]  ct = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                held = 1'b0;
            end else if (m.rsp_valid) begin
                if (!held) begin
                    if (q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_rsp: got data %h tag %0d, expected none", m.rsp_data, m.rsp_tag);
                    end else begin
                        check("rsp_cycle", 32'(cyc), 32'(q[0].cyc));
                    end
                    cd = m.rsp_data;
                    ct = m.rsp_tag;
                end else begin
                    check("hold_data", m.rsp_data, cd);
                    check("hold_tag", {27'd0, m.rsp_tag}, {27'd0, ct});
                end
                if (m.rsp_ready) begin
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        check("rsp_data", m.rsp_data, e.data);
                        check("rsp_tag", {27'd0, m.rsp_tag}, {27'd0, e.tag});
                    end
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        int acc;
        int hs;
        int n;
        bit seen;
        rst_n = 1'b0; flush = 1'b0;
        m.req_valid = 1'b0; m.req_funct3 = '0; m.req_rs1 = '0; m.req_rs2 = '0; m.req_tag = '0;
        m.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'd0, m.req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, m.rsp_valid}, 32'd0);
        check("rst_rsp_data", m.rsp_data, 32'd0);
        check("rst_rsp_tag", {27'd0, m.rsp_tag}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Multiplies
        issue(3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, LM, 1, acc);
        issue(3'b001, 32'h80000000, 32'h80000000, 5'd1, 32'h40000000, LM, 1, acc);
        issue(3'b010, 32'h80000000, 32'h80000000, 5'd2, 32'hC0000000, LM, 1, acc);
        issue(3'b011, 32'h80000000, 32'h80000000, 5'd3, 32'h40000000, LM, 1, acc);
        issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFE, LM, 1, acc);
        drain();

        // Divides
        issue(3'b100, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFD, LD, 1, acc);
        issue(3'b110, 32'hFFFFFFF9, 32'd2, 5'd7, 32'hFFFFFFFF, LD, 1, acc);
        issue(3'b100, 32'd7, 32'hFFFFFFFE, 5'd8, 32'hFFFFFFFD, LD, 1, acc);
        issue(3'b110, 32'd7, 32'hFFFFFFFE, 5'd9, 32'd1, LD, 1, acc);
        issue(3'b101, 32'd100, 32'd7, 5'd10, 32'd14, LD, 1, acc);
        issue(3'b111, 32'd100, 32'd7, 5'd11, 32'd2, LD, 1, acc);
        drain();

        // Special divides
        issue(3'b101, 32'd5, 32'd0, 5'd12, 32'hFFFFFFFF, 1, 1, acc);
        issue(3'b110, 32'd5, 32'd0, 5'd13, 32'd5, 1, 1, acc);
        issue(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 1, 1, acc);
        issue(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0, 1, 1, acc);
        drain();

        // Backpressure
        m.rsp_ready = 1'b0;
        issue(3'b101, 32'd100, 32'd7, 5'd16, 32'd14, LD, 1, acc);
        n = 0;
        while (!m.rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests++; fails++;
            $display("FAIL bp_wait: rsp_valid stayed %b, expected 1", m.rsp_valid);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_req_ready", {31'd0, m.req_ready}, 32'd0);
            check("bp_rsp_valid", {31'd0, m.rsp_valid}, 32'd1);
        end
        m.rsp_ready = 1'b1;
        hs = cyc;
        issue(3'b000, 32'd3, 32'd4, 5'd17, 32'd12, LM, 1, acc);
        check("bp_accept_cycle", 32'(acc), 32'(hs + 1));
        drain();

        // Flush wins over a simultaneous request
        m.req_valid = 1'b1; m.req_funct3 = 3'b100; m.req_rs1 = 32'd8; m.req_rs2 = 32'd2; m.req_tag = 5'd18;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; m.req_valid = 1'b0;
        check("flush_req_busy", {31'd0, busy}, 32'd0);
        check("flush_req_ready", {31'd0, m.req_ready}, 32'd1);

        // Flush mid-divide
        issue(3'b100, 32'd1000, 32'd3, 5'd19, 32'd0, LD, 0, acc);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_req_ready", {31'd0, m.req_ready}, 32'd1);
        check("flush_rsp_valid", {31'd0, m.rsp_valid}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m.rsp_valid) seen = 1'b1;
        end
        check("flush_no_rsp", {31'd0, seen}, 32'd0);

        // Asynchronous reset mid-divide
        issue(3'b100, 32'd1000, 32'd3, 5'd9, 32'd0, LD, 0, acc);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_req_ready", {31'd0, m.req_ready}, 32'd1);
        check("arst_rsp_valid", {31'd0, m.rsp_valid}, 32'd0);
        check("arst_rsp_data", m.rsp_data, 32'd0);
        check("arst_rsp_tag", {27'd0, m.rsp_tag}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd20, 32'd0, LM, 1, acc);
        issue(3'b111, 32'hFFFFFFFF, 32'h00010000, 5'd21, 32'h0000FFFF, LD, 1, acc);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
